// File: rtl/scratchpad_array.sv
// Scratchpad register-pair array with nibble/row access, periodic refresh and power-on clear.
// Every access runs PRE -> RD -> WB: the row is read into a row buffer and written back
// (restored or modified). Refresh reuses the same three states.
module scratchpad_array #(
  parameter int NIB_W         = 4,
  parameter int COLS          = 2,
  parameter int ROWS          = 8,
  parameter int RFSH_INTERVAL = 32,
  localparam int ROW_W        = NIB_W * COLS,
  localparam int RW           = $clog2(ROWS),
  localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int TW           = $clog2(RFSH_INTERVAL)
) (
  input  logic             sysclk,
  input  logic             poc,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RW-1:0]    cmd_row,
  input  logic [CW-1:0]    cmd_col,
  input  logic [ROW_W-1:0] cmd_wdata,
  output logic             rd_valid,
  output logic [ROW_W-1:0] rd_data,
  output logic             cmd_err,
  output logic [RW-1:0]    rfsh_row,
  output logic             rfsh_overrun,
  output logic             busy
);

  typedef enum logic [2:0] {CLEAR, IDLE, PRE, RD, WB} state_t;

  state_t           state;
  logic [ROW_W-1:0] mem [ROWS];
  logic [RW-1:0]    clr_row;
  logic [TW-1:0]    timer;
  logic             rfsh_pending;
  logic             rfsh_flag;
  logic [1:0]       op_reg;
  logic [RW-1:0]    row_reg;
  logic [CW-1:0]    col_reg;
  logic [ROW_W-1:0] wdata_reg;
  logic             err_reg;
  logic [ROW_W-1:0] row_buf;
  logic [ROW_W-1:0] merged;
  logic [NIB_W-1:0] sel_nib;
  logic             cmd_bad;
  logic             timer_wrap;
  logic             rfsh_done;
  logic [RW-1:0]    acc_row;
  logic             mem_we;
  logic [RW-1:0]    mem_waddr;
  logic [ROW_W-1:0] mem_wdata;

  assign cmd_ready  = (state == IDLE) && !rfsh_pending;
  assign busy       = (state != IDLE);
  // Row range is checked for every op; column range only matters for nibble ops.
  assign cmd_bad    = ({1'b0, cmd_row} >= (RW+1)'(ROWS)) ||
                      (!cmd_op[1] && ({1'b0, cmd_col} >= (CW+1)'(COLS)));
  assign timer_wrap = (state != CLEAR) && (timer == TW'(RFSH_INTERVAL - 1));
  assign rfsh_done  = (state == WB) && rfsh_flag;
  assign acc_row    = rfsh_flag ? rfsh_row : row_reg;

  // Row buffer with the addressed nibble replaced by the write data.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_nib
    assign merged[gi*NIB_W +: NIB_W] = (col_reg == CW'(gi)) ? wdata_reg[NIB_W-1:0]
                                                            : row_buf[gi*NIB_W +: NIB_W];
  end

  // Select the addressed nibble of the row buffer for nibble reads.
  always_comb begin
    sel_nib = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_reg == CW'(c)) sel_nib = row_buf[c*NIB_W +: NIB_W];
    end
  end

  // Array write port: zero fill during CLEAR, restore/modify in WB; poc discards any write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = acc_row;
    mem_wdata = row_buf;
    if (!poc) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_row;
        mem_wdata = '0;
      end else if ((state == WB) && (rfsh_flag || !err_reg)) begin
        mem_we = 1'b1;
        if (!rfsh_flag && (op_reg == 2'b01)) mem_wdata = merged;
        else if (!rfsh_flag && (op_reg == 2'b11)) mem_wdata = wdata_reg;
      end
    end
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM, refresh timer and registered outputs.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state        <= CLEAR;
      clr_row      <= '0;
      timer        <= '0;
      rfsh_row     <= '0;
      rfsh_pending <= 1'b0;
      rfsh_overrun <= 1'b0;
      rfsh_flag    <= 1'b0;
      rd_valid     <= 1'b0;
      cmd_err      <= 1'b0;
      rd_data      <= '0;
      row_buf      <= '0;
      op_reg       <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (state != CLEAR) timer <= timer_wrap ? '0 : timer + 1'b1;
      // A new request wins over the clear issued by a refresh finishing on the same edge.
      if (timer_wrap) rfsh_pending <= 1'b1;
      else if (rfsh_done) rfsh_pending <= 1'b0;
      if (timer_wrap && rfsh_pending && !rfsh_done) rfsh_overrun <= 1'b1;
      case (state)
        CLEAR: begin
          clr_row <= clr_row + 1'b1;
          if (clr_row == RW'(ROWS - 1)) begin
            clr_row <= '0;
            state   <= IDLE;
          end
        end
        IDLE: begin
          if (rfsh_pending) begin
            rfsh_flag <= 1'b1;
            row_buf   <= '0;
            state     <= PRE;
          end else if (cmd_valid) begin
            rfsh_flag <= 1'b0;
            op_reg    <= cmd_op;
            row_reg   <= cmd_row;
            col_reg   <= cmd_col;
            wdata_reg <= cmd_wdata;
            err_reg   <= cmd_bad;
            row_buf   <= '0;
            state     <= PRE;
          end
        end
        PRE: begin
          if (rfsh_flag || !err_reg) row_buf <= mem[acc_row];
          state <= RD;
        end
        RD: begin
          if (!rfsh_flag) begin
            cmd_err <= err_reg;
            if (!op_reg[0]) begin
              rd_valid <= 1'b1;
              if (err_reg) rd_data <= '0;
              else if (op_reg[1]) rd_data <= row_buf;
              else rd_data <= ROW_W'(sel_nib);
            end
          end
          state <= WB;
        end
        WB: begin
          if (rfsh_flag) rfsh_row <= (rfsh_row == RW'(ROWS - 1)) ? '0 : rfsh_row + 1'b1;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_array.sv
// Testbench for scratchpad_array. Uses a small configuration (3 nibbles, 6 rows, refresh every
// 8 cycles) so out-of-range rows and columns are encodable and refresh interleaves with traffic.
module tb_scratchpad_array;

  localparam int NIB_W = 4;
  localparam int COLS  = 3;
  localparam int ROWS  = 6;
  localparam int RFSH  = 8;
  localparam int ROW_W = NIB_W * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  logic             sysclk = 1'b0;
  logic             poc = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [RW-1:0]    cmd_row = '0;
  logic [CW-1:0]    cmd_col = '0;
  logic [ROW_W-1:0] cmd_wdata = '0;
  logic             rd_valid;
  logic [ROW_W-1:0] rd_data;
  logic             cmd_err;
  logic [RW-1:0]    rfsh_row;
  logic             rfsh_overrun;
  logic             busy;

  int checks = 0;
  int errors = 0;

  scratchpad_array #(.NIB_W(NIB_W), .COLS(COLS), .ROWS(ROWS), .RFSH_INTERVAL(RFSH)) dut (
    .sysclk(sysclk), .poc(poc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd_err(cmd_err), .rfsh_row(rfsh_row),
    .rfsh_overrun(rfsh_overrun), .busy(busy)
  );

  always #10 sysclk = ~sysclk;

  // Behavioural model: memory contents plus countdowns for clear and for the 3-cycle operation.
  logic [ROW_W-1:0] m_mem [ROWS];
  logic [ROW_W-1:0] nmask = ROW_W'((1 << NIB_W) - 1);
  int               m_clear_left = 0, m_left = 0, m_timer = 0, m_rrow = 0;
  bit               m_pending = 0, m_overrun = 0, m_is_rfsh = 0, m_bad = 0, m_acc = 0, d_acc = 0;
  logic [1:0]       m_op = '0;
  int               m_row = 0, m_col = 0;
  logic [ROW_W-1:0] m_wdata = '0, m_rd_data = '0;
  bit               m_rd_valid = 0, m_err = 0;

  function automatic bit exp_ready();
    return (m_clear_left == 0) && (m_left == 0) && !m_pending;
  endfunction

  function automatic bit exp_busy();
    return (m_clear_left > 0) || (m_left > 0);
  endfunction

  // Advance one clock: the model consumes the same inputs the DUT samples, then time moves
  // 1 ns past the edge so outputs can be inspected and new inputs driven.
  task automatic step();
    bit wrap, done;
    d_acc = cmd_valid && cmd_ready;
    @(posedge sysclk);
    m_acc = 0;
    if (poc) begin
      m_clear_left = ROWS; m_left = 0; m_timer = 0; m_pending = 0; m_overrun = 0;
      m_rrow = 0; m_rd_valid = 0; m_err = 0; m_rd_data = '0;
      for (int r = 0; r < ROWS; r++) m_mem[r] = '0;
    end else begin
      m_rd_valid = 0; m_err = 0; wrap = 0; done = 0;
      if (m_clear_left == 0) begin
        if (m_timer == RFSH - 1) begin m_timer = 0; wrap = 1; end
        else m_timer++;
      end
      if (m_clear_left > 0) m_clear_left--;
      else if (m_left > 0) begin
        if (m_left == 2 && !m_is_rfsh) begin
          m_err = m_bad;
          if (!m_op[0]) begin
            m_rd_valid = 1;
            if (m_bad) m_rd_data = '0;
            else if (m_op[1]) m_rd_data = m_mem[m_row];
            else m_rd_data = (m_mem[m_row] >> (NIB_W * m_col)) & nmask;
          end
        end
        if (m_left == 1) begin
          if (m_is_rfsh) begin
            done = 1; m_rrow = (m_rrow + 1) % ROWS;
          end else if (!m_bad && m_op[0]) begin
            if (m_op[1]) m_mem[m_row] = m_wdata;
            else m_mem[m_row] = (m_mem[m_row] & ~(nmask << (NIB_W * m_col))) |
                                ((m_wdata & nmask) << (NIB_W * m_col));
          end
        end
        m_left--;
      end else if (m_pending) begin
        m_is_rfsh = 1; m_left = 3;
      end else if (cmd_valid) begin
        m_is_rfsh = 0; m_left = 3; m_acc = 1;
        m_op = cmd_op; m_row = int'(cmd_row); m_col = int'(cmd_col); m_wdata = cmd_wdata;
        m_bad = (m_row >= ROWS) || (!cmd_op[1] && m_col >= COLS);
      end
      if (wrap && m_pending && !done) m_overrun = 1;
      if (wrap) m_pending = 1;
      else if (done) m_pending = 0;
    end
    #1;
  endtask

  // Present a command and hold it until the model accepts it; returns in the PRE cycle.
  task automatic send(input logic [1:0] op, input int row, input int col, input logic [ROW_W-1:0] wd);
    cmd_op = op; cmd_row = RW'(row); cmd_col = CW'(col); cmd_wdata = wd; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_acc) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    poc = 1'b1; cmd_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold busy=%b ready=%b, need busy=1 ready=0", busy, cmd_ready);
    end
    checks++;
    if ({rd_valid, cmd_err, rd_data, rfsh_row, rfsh_overrun} !== '0) begin
      errors++; $display("FAIL reset_flags rd_valid=%b err=%b data=%h rrow=%0d ovr=%b, need all 0",
                         rd_valid, cmd_err, rd_data, rfsh_row, rfsh_overrun);
    end
    poc = 1'b0;
    first = -1;
    for (int k = 1; k <= ROWS + 4; k++) begin
      step();
      checks++;
      if (busy !== (k < ROWS)) begin
        errors++; $display("FAIL clear_busy cycle=%0d busy=%b need=%b", k, busy, k < ROWS);
      end
      if (first < 0 && cmd_ready === 1'b1) first = k;
    end
    checks++;
    if (first !== ROWS) begin
      errors++; $display("FAIL ready_rise cycles=%0d need=%0d", first, ROWS);
    end
    for (int r = 0; r < ROWS; r++) begin
      send(2'b10, r, 0, ROW_W'($urandom));
      step(); step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
        errors++; $display("FAIL clear_row%0d rd_valid=%b data=%h need 1/000", r, rd_valid, rd_data);
      end
      step();
    end
  endtask

  task automatic test_rw_directed();
    send(2'b11, 3, 0, 12'h0A5); step(); step(); step();
    send(2'b01, 3, 0, 12'hFF7); step(); step(); step();
    send(2'b10, 3, 0, ROW_W'($urandom)); step(); step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 12'h0A7 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL read_row3 rd_valid=%b data=%h err=%b need 1/0a7/0", rd_valid, rd_data, cmd_err);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 12'h0A7) begin
      errors++; $display("FAIL hold_after_strobe rd_valid=%b data=%h need 0/0a7", rd_valid, rd_data);
    end
    send(2'b00, 3, 1, ROW_W'($urandom)); step(); step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 12'h00A) begin
      errors++; $display("FAIL read_nib_col1 rd_valid=%b data=%h need 1/00a", rd_valid, rd_data);
    end
    step();
    send(2'b00, 3, 2, ROW_W'($urandom)); step(); step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 12'h000) begin
      errors++; $display("FAIL read_nib_col2 rd_valid=%b data=%h need 1/000", rd_valid, rd_data);
    end
    step();
  endtask

  task automatic test_errors();
    send(2'b01, 3, 3, 12'hFFF); step(); step();
    checks++;
    if (cmd_err !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL err_wr_col err=%b rd_valid=%b need 1/0", cmd_err, rd_valid);
    end
    step();
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width err=%b need 0", cmd_err);
    end
    send(2'b00, 3, 3, '0); step(); step();
    checks++;
    if (cmd_err !== 1'b1 || rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++; $display("FAIL err_rd_col err=%b rd_valid=%b data=%h need 1/1/000", cmd_err, rd_valid, rd_data);
    end
    step();
    send(2'b11, 6, 0, 12'h123); step(); step();
    checks++;
    if (cmd_err !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL err_wr_row err=%b rd_valid=%b need 1/0", cmd_err, rd_valid);
    end
    step();
    send(2'b10, 7, 0, '0); step(); step();
    checks++;
    if (cmd_err !== 1'b1 || rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++; $display("FAIL err_rd_row err=%b rd_valid=%b data=%h need 1/1/000", cmd_err, rd_valid, rd_data);
    end
    step();
    send(2'b10, 3, 0, '0); step(); step();
    checks++;
    if (rd_data !== 12'h0A7 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL err_untouched data=%h err=%b need 0a7/0", rd_data, cmd_err);
    end
    step();
  endtask

  task automatic test_refresh();
    logic [ROW_W-1:0] val;
    int waited;
    bit accepted;
    poc = 1'b1; step(); poc = 1'b0;
    for (int i = 0; i < 40 && !exp_ready(); i++) step();
    val = ROW_W'($urandom_range(1, 4095));
    send(2'b11, 0, 0, val);
    for (int i = 0; i < 40 && !(m_pending && m_left == 0); i++) step();
    checks++;
    if (cmd_ready !== 1'b0 || rfsh_row !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rfsh_pending ready=%b rrow=%0d busy=%b need 0/0/0", cmd_ready, rfsh_row, busy);
    end
    cmd_op = 2'b10; cmd_row = '0; cmd_col = '0; cmd_valid = 1'b1;
    waited = 0; accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin accepted = 1; step(); break; end
      if (i >= 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL rfsh_busy cycle=%0d busy=%b need 1", i, busy);
        end
      end
      waited++;
      step();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!accepted || waited !== 4) begin
      errors++; $display("FAIL rfsh_wait accepted=%b waited=%0d need 1/4", accepted, waited);
    end
    checks++;
    if (rfsh_row !== RW'(1)) begin
      errors++; $display("FAIL rfsh_row_inc rrow=%0d need 1", rfsh_row);
    end
    step(); step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== val) begin
      errors++; $display("FAIL rfsh_data rd_valid=%b data=%h need 1/%h", rd_valid, rd_data, val);
    end
    step();
  endtask

  // First 100 cycles hold cmd_valid high (back-to-back), then random gaps; every output is
  // compared with the model on every cycle.
  task automatic test_random_traffic();
    int last_acc, reads_acc, reads_seen, gap;
    last_acc = -1; reads_acc = 0; reads_seen = 0;
    cmd_op = 2'($urandom); cmd_row = RW'($urandom_range(0, 7));
    cmd_col = CW'($urandom_range(0, 3)); cmd_wdata = ROW_W'($urandom);
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      checks++;
      if (d_acc !== m_acc) begin
        errors++; $display("FAIL accept cyc=%0d got=%b need=%b", i, d_acc, m_acc);
      end
      checks++;
      if (cmd_ready !== exp_ready() || busy !== exp_busy()) begin
        errors++; $display("FAIL ready_busy cyc=%0d ready=%b busy=%b need %b/%b", i, cmd_ready, busy, exp_ready(), exp_busy());
      end
      checks++;
      if (rd_valid !== m_rd_valid || rd_data !== m_rd_data || cmd_err !== m_err) begin
        errors++; $display("FAIL rd_out cyc=%0d valid=%b data=%h err=%b need %b/%h/%b",
                           i, rd_valid, rd_data, cmd_err, m_rd_valid, m_rd_data, m_err);
      end
      checks++;
      if (rfsh_row !== RW'(m_rrow) || rfsh_overrun !== m_overrun) begin
        errors++; $display("FAIL rfsh_state cyc=%0d rrow=%0d ovr=%b need %0d/%b", i, rfsh_row, rfsh_overrun, m_rrow, m_overrun);
      end
      if (i < 100) begin
        if (rd_valid === 1'b1) reads_seen++;
        if (d_acc) begin
          if (!cmd_op[0]) reads_acc++;
          if (last_acc >= 0) begin
            gap = i - last_acc;
            checks++;
            if (gap != 4 && gap != 8) begin
              errors++; $display("FAIL b2b_gap cyc=%0d gap=%0d need 4 or 8", i, gap);
            end
          end
          last_acc = i;
        end
      end
      if (i == 103) begin
        checks++;
        if (reads_seen !== reads_acc) begin
          errors++; $display("FAIL b2b_reads strobes=%0d need %0d", reads_seen, reads_acc);
        end
      end
      if (m_acc || (i >= 100 && !cmd_valid)) begin
        cmd_op = 2'($urandom); cmd_row = RW'($urandom_range(0, 7));
        cmd_col = CW'($urandom_range(0, 3)); cmd_wdata = ROW_W'($urandom);
        cmd_valid = (i < 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
    end
    cmd_valid = 1'b0;
    step(); step(); step(); step();
  endtask

  task automatic test_poc_midaccess();
    send(2'b11, 2, 0, 12'h5C3);
    step();
    poc = 1'b1;
    step();
    poc = 1'b0;
    checks++;
    if ({rd_valid, cmd_err, rd_data, rfsh_row, rfsh_overrun} !== '0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL poc_mid flags valid=%b err=%b data=%h rrow=%0d ovr=%b busy=%b ready=%b",
                         rd_valid, cmd_err, rd_data, rfsh_row, rfsh_overrun, busy, cmd_ready);
    end
    for (int i = 0; i < 40 && !exp_ready(); i++) step();
    send(2'b10, 2, 0, '0); step(); step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++; $display("FAIL poc_discard rd_valid=%b data=%h need 1/000", rd_valid, rd_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_rw_directed();
    test_errors();
    test_refresh();
    test_random_traffic();
    test_poc_midaccess();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
